// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one icache block request at a time, delivers the
// fetched slots to the instruction FIFO and follows predictions and redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          BLOCK_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        full_ififo,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_pc,
    input  logic        ic_req_ready,
    input  logic        ic_resp_valid,
    output logic        ic_resp_ready,
    input  logic        bp_taken,
    input  logic [1:0]  bp_slot,
    input  logic [31:0] bp_target,
    output logic [3:0]  valid_inst,
    output logic [31:0] fetch_pc,
    output logic        flush_ififo
);

    // Handshakes: a request transfers on ic_req_valid & ic_req_ready; a
    // response is consumed on ic_resp_valid & ic_resp_ready. Only one
    // request is ever outstanding (WAIT or DRAIN).
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        flush_next;
    logic        req_fire;
    logic        consume;
    logic        taken;
    logic [1:0]  off;
    logic [1:0]  last_slot;
    logic [2:0]  n_inst;
    logic [31:0] seq_pc;

    always_comb begin
        state_next    = state;
        pc_next       = pc_reg;
        flush_next    = 1'b0;
        ic_req_valid  = (state == RUN) && !rst;
        ic_req_pc     = pc_reg;
        ic_resp_ready = 1'b0;
        valid_inst    = 4'b0000;
        fetch_pc      = 32'h0;
        consume       = 1'b0;

        off       = pc_reg[3:2];
        taken     = bp_taken && (bp_slot >= off);
        last_slot = taken ? bp_slot : 2'd3;
        n_inst    = {1'b0, last_slot} - {1'b0, off} + 3'd1;
        seq_pc    = {pc_reg[31:4], 4'b0000} + 32'(BLOCK_BYTES);
        req_fire  = ic_req_valid && ic_req_ready;

        case (state)
            RUN: begin
                if (req_fire) state_next = WAIT;
            end
            WAIT: begin
                ic_resp_ready = !full_ififo && !redirect_valid;
                consume       = ic_resp_valid && ic_resp_ready;
                if (consume) begin
                    fetch_pc   = pc_reg;
                    state_next = RUN;
                    pc_next    = taken ? (bp_target & ~32'h3) : seq_pc;
                    case (n_inst)
                        3'd1:    valid_inst = 4'b0001;
                        3'd2:    valid_inst = 4'b0011;
                        3'd3:    valid_inst = 4'b0111;
                        default: valid_inst = 4'b1111;
                    endcase
                end
            end
            DRAIN: begin
                // Stale response is accepted and thrown away.
                ic_resp_ready = !redirect_valid;
                if (ic_resp_valid && ic_resp_ready) state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        // Redirect wins over consume and prediction; a request already in
        // flight must be drained before refetching.
        if (redirect_valid) begin
            pc_next    = redirect_pc & ~32'h3;
            flush_next = 1'b1;
            state_next = (state == RUN && !req_fire) ? RUN : DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc_reg      <= RESET_PC;
            flush_ififo <= 1'b0;
        end else begin
            state       <= state_next;
            pc_reg      <= pc_next;
            flush_ififo <= flush_next;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of single-block fetches plus
// hand-written redirect, back-to-back redirect and mid-WAIT reset sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        full_ififo;
    logic        ic_req_valid;
    logic [31:0] ic_req_pc;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic        ic_resp_ready;
    logic        bp_taken;
    logic [1:0]  bp_slot;
    logic [31:0] bp_target;
    logic [3:0]  valid_inst;
    logic [31:0] fetch_pc;
    logic        flush_ififo;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] rd_pc;
        logic [31:0] exp_pc;
        logic        taken;
        logic [1:0]  slot;
        logic [31:0] target;
        logic [3:0]  mask;
        logic [31:0] next_pc;
        int          full_cycles;
    } fetch_vec_t;

    fetch_vec_t vecs[8];

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .full_ififo     (full_ififo),
        .ic_req_valid   (ic_req_valid),
        .ic_req_pc      (ic_req_pc),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_ready  (ic_resp_ready),
        .bp_taken       (bp_taken),
        .bp_slot        (bp_slot),
        .bp_target      (bp_target),
        .valid_inst     (valid_inst),
        .fetch_pc       (fetch_pc),
        .flush_ififo    (flush_ififo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue from RUN, optionally stall on a full FIFO, then consume.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic tk, input logic [1:0] slot,
                            input logic [31:0] target, input logic [3:0] mask,
                            input logic [31:0] next_pc, input int full_cycles);
        chk("req_valid_run", 32'(ic_req_valid), 32'd1);
        chk("req_pc", ic_req_pc, exp_pc);
        ic_req_ready = 1'b1;
        step();
        ic_req_ready = 1'b0;
        #1;
        chk("one_outstanding", 32'(ic_req_valid), 32'd0);
        step();
        ic_resp_valid = 1'b1;
        bp_taken      = tk;
        bp_slot       = slot;
        bp_target     = target;
        for (int i = 0; i < full_cycles; i++) begin
            full_ififo = 1'b1;
            #1;
            chk("full_valid_inst", 32'(valid_inst), 32'd0);
            chk("full_resp_ready", 32'(ic_resp_ready), 32'd0);
            step();
        end
        full_ififo = 1'b0;
        #1;
        chk("resp_ready", 32'(ic_resp_ready), 32'd1);
        chk("valid_inst", 32'(valid_inst), 32'(mask));
        chk("fetch_pc", fetch_pc, exp_pc);
        step();
        ic_resp_valid = 1'b0;
        bp_taken      = 1'b0;
        #1;
        chk("idle_valid_inst", 32'(valid_inst), 32'd0);
        chk("next_req_valid", 32'(ic_req_valid), 32'd1);
        chk("next_req_pc", ic_req_pc, next_pc);
    endtask

    // Redirect from RUN with no handshake: stays RUN, one flush pulse.
    task automatic redirect_run(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("flush_pulse", 32'(flush_ififo), 32'd1);
        step();
        chk("flush_one_cycle", 32'(flush_ififo), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h1c000008, 32'h1c000008, 1'b1, 2'd3, 32'h1c000100, 4'b0011, 32'h1c000100, 0};
        vecs[1] = '{32'h1c000008, 32'h1c000008, 1'b1, 2'd1, 32'h1c000100, 4'b0011, 32'h1c000010, 0};
        vecs[2] = '{32'h1c000004, 32'h1c000004, 1'b1, 2'd2, 32'h1c000400, 4'b0011, 32'h1c000400, 5};
        vecs[3] = '{32'h1c00000c, 32'h1c00000c, 1'b0, 2'd0, 32'h0,        4'b0001, 32'h1c000010, 0};
        vecs[4] = '{32'h1c000000, 32'h1c000000, 1'b1, 2'd0, 32'h1c000020, 4'b0001, 32'h1c000020, 0};
        vecs[5] = '{32'hfffffff0, 32'hfffffff0, 1'b0, 2'd0, 32'h0,        4'b1111, 32'h00000000, 0};
        vecs[6] = '{32'h1c000206, 32'h1c000204, 1'b0, 2'd0, 32'h0,        4'b0111, 32'h1c000210, 0};
        vecs[7] = '{32'h1c000008, 32'h1c000008, 1'b1, 2'd2, 32'h1c000103, 4'b0001, 32'h1c000100, 0};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        full_ififo     = 1'b0;
        ic_req_ready   = 1'b0;
        ic_resp_valid  = 1'b0;
        bp_taken       = 1'b0;
        bp_slot        = 2'd0;
        bp_target      = 32'h0;
        #3;
        chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
        chk("rst_resp_ready", 32'(ic_resp_ready), 32'd0);
        chk("rst_valid_inst", 32'(valid_inst), 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_flush", 32'(flush_ififo), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;

        // First fetch out of reset
        do_fetch(32'h1c000000, 1'b0, 2'd0, 32'h0, 4'b1111, 32'h1c000010, 0);

        for (int v = 0; v < 8; v++) begin
            redirect_run(vecs[v].rd_pc);
            do_fetch(vecs[v].exp_pc, vecs[v].taken, vecs[v].slot, vecs[v].target,
                     vecs[v].mask, vecs[v].next_pc, vecs[v].full_cycles);
        end

        // Redirect while WAIT with a response pending
        ic_req_ready = 1'b1;
        step();
        ic_req_ready   = 1'b0;
        ic_resp_valid  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000204;
        #1;
        chk("redir_resp_ready", 32'(ic_resp_ready), 32'd0);
        chk("redir_valid_inst", 32'(valid_inst), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("drain_flush", 32'(flush_ififo), 32'd1);
        chk("drain_resp_ready", 32'(ic_resp_ready), 32'd1);
        chk("drain_valid_inst", 32'(valid_inst), 32'd0);
        chk("drain_req_valid", 32'(ic_req_valid), 32'd0);
        step();
        ic_resp_valid = 1'b0;
        #1;
        chk("drain_flush_end", 32'(flush_ififo), 32'd0);
        do_fetch(32'h1c000204, 1'b0, 2'd0, 32'h0, 4'b0111, 32'h1c000210, 0);

        // Back-to-back redirects from WAIT
        ic_req_ready = 1'b1;
        step();
        ic_req_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000300;
        step();
        redirect_pc = 32'h1c000400;
        #1;
        chk("b2b_flush1", 32'(flush_ififo), 32'd1);
        step();
        redirect_valid = 1'b0;
        ic_resp_valid  = 1'b1;
        #1;
        chk("b2b_flush2", 32'(flush_ififo), 32'd1);
        chk("b2b_drain_req", 32'(ic_req_valid), 32'd0);
        chk("b2b_drain_vi", 32'(valid_inst), 32'd0);
        chk("b2b_drain_ready", 32'(ic_resp_ready), 32'd1);
        step();
        ic_resp_valid = 1'b0;
        #1;
        chk("b2b_flush_end", 32'(flush_ififo), 32'd0);
        do_fetch(32'h1c000400, 1'b0, 2'd0, 32'h0, 4'b1111, 32'h1c000410, 0);

        // Reset in the middle of WAIT
        ic_req_ready = 1'b1;
        step();
        ic_req_ready  = 1'b0;
        ic_resp_valid = 1'b1;
        rst           = 1'b1;
        #1;
        chk("midrst_req_valid", 32'(ic_req_valid), 32'd0);
        chk("midrst_valid_inst", 32'(valid_inst), 32'd0);
        chk("midrst_resp_ready", 32'(ic_resp_ready), 32'd0);
        step();
        ic_resp_valid = 1'b0;
        rst           = 1'b0;
        #1;
        chk("midrst_req_pc", ic_req_pc, 32'h1c000000);
        chk("midrst_req_again", 32'(ic_req_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
